vga_timing_generator: RTL and testbench

VGA_TIMING_GENERATOR -- requirements
Module: vga_timing_generator

---
 rtl/vga_timing_generator_if.sv | 39 +++
 rtl/vga_timing_generator.sv | 146 ++++++++++++++
 tb/tb_vga_timing_generator.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_generator_if.sv
// Purpose: pixel-request and DAC-side signal bundle for the VGA timing generator.
// Ports: master = generator (drives request, coordinates, pulses, DAC outputs; samples colour),
//        slave = pixel source / DAC consumer (mirror directions).
interface vga_timing_generator_if #(
  parameter int COLOR_WIDTH = 8
);
  // Pixel request side
  logic                   pixel_request;
  logic [11:0]            pixel_x_pos;
  logic [11:0]            pixel_y_pos;
  logic [COLOR_WIDTH-1:0] pixel_red;
  logic [COLOR_WIDTH-1:0] pixel_green;
  logic [COLOR_WIDTH-1:0] pixel_blue;
  logic                   frame_start;
  logic                   vblank_start;
  // DAC / connector side
  logic [COLOR_WIDTH-1:0] vga_red;
  logic [COLOR_WIDTH-1:0] vga_green;
  logic [COLOR_WIDTH-1:0] vga_blue;
  logic                   vga_clock;
  logic                   vga_horizontal_sync;
  logic                   vga_vertical_sync;
  logic                   vga_blank;
  logic                   vga_sync;

  modport master (
    output pixel_request, pixel_x_pos, pixel_y_pos, frame_start, vblank_start,
    input  pixel_red, pixel_green, pixel_blue,
    output vga_red, vga_green, vga_blue, vga_clock,
    output vga_horizontal_sync, vga_vertical_sync, vga_blank, vga_sync
  );

  modport slave (
    input  pixel_request, pixel_x_pos, pixel_y_pos, frame_start, vblank_start,
    output pixel_red, pixel_green, pixel_blue,
    input  vga_red, vga_green, vga_blue, vga_clock,
    input  vga_horizontal_sync, vga_vertical_sync, vga_blank, vga_sync
  );
endinterface

// File: rtl/vga_timing_generator.sv
// Purpose: VGA raster timing: x/y counters, pixel requests, frame/vblank pulses, and a
//          latency-matched registered DAC output stage (colour, syncs, blank, composite sync).
// Ports: clock (pixel clock), reset (async active-low), enable (run / hold at origin),
//        vga (vga_timing_generator_if.master: request/colour bus and DAC outputs).
module vga_timing_generator #(
  parameter int H_ACTIVE       = 640,
  parameter int H_FRONT_PORCH  = 16,
  parameter int H_SYNC_PULSE   = 96,
  parameter int H_BACK_PORCH   = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_FRONT_PORCH  = 10,
  parameter int V_SYNC_PULSE   = 2,
  parameter int V_BACK_PORCH   = 33,
  parameter int HSYNC_POLARITY = 0,
  parameter int VSYNC_POLARITY = 0,
  parameter int COLOR_WIDTH    = 8,
  parameter int PIXEL_LATENCY  = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  vga_timing_generator_if.master vga
);

  // Totals must fit the 12-bit counters (at most 4095).
  localparam int H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEGIN = 12'(H_ACTIVE + H_FRONT_PORCH);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [11:0] VS_BEGIN = 12'(V_ACTIVE + V_FRONT_PORCH);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FRONT_PORCH + V_SYNC_PULSE);

  // Level driven while a sync pulse is active.
  localparam logic HS_ON = (HSYNC_POLARITY != 0);
  localparam logic VS_ON = (VSYNC_POLARITY != 0);

  logic [11:0] x_cnt;
  logic [11:0] y_cnt;

  // Raster counters; y advances only on the x wrap cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (!enable) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (x_cnt == H_LAST) begin
      x_cnt <= '0;
      y_cnt <= (y_cnt == V_LAST) ? 12'd0 : y_cnt + 12'd1;
    end else begin
      x_cnt <= x_cnt + 12'd1;
    end
  end

  logic in_active;
  logic raw_hs;
  logic raw_vs;

  assign in_active = enable && (x_cnt < H_ACT) && (y_cnt < V_ACT);
  assign raw_hs    = enable && (x_cnt >= HS_BEGIN) && (x_cnt < HS_END);
  assign raw_vs    = enable && (y_cnt >= VS_BEGIN) && (y_cnt < VS_END);

  assign vga.pixel_request = in_active;
  assign vga.pixel_x_pos   = in_active ? x_cnt : 12'd0;
  assign vga.pixel_y_pos   = in_active ? y_cnt : 12'd0;
  assign vga.frame_start   = enable && (x_cnt == 12'd0) && (y_cnt == 12'd0);
  assign vga.vblank_start  = enable && (x_cnt == 12'd0) && (y_cnt == V_ACT);
  assign vga.vga_clock     = clock;

  // Flags {active, hsync, vsync} delayed by PIXEL_LATENCY cycles; the output
  // register below supplies the final stage, so the total delay is
  // PIXEL_LATENCY+1 and lines up with colour arriving PIXEL_LATENCY cycles
  // after its request. Disabled cycles shift zeros in via the gated raw flags.
  logic [2:0] raw_flags;
  logic [2:0] late_flags;

  assign raw_flags = {in_active, raw_hs, raw_vs};

  generate
    if (PIXEL_LATENCY == 0) begin : g_no_dly
      assign late_flags = raw_flags;
    end else begin : g_dly
      logic [2:0] dly_q [PIXEL_LATENCY];
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < PIXEL_LATENCY; k++) dly_q[k] <= '0;
        end else begin
          dly_q[0] <= raw_flags;
          for (int k = 1; k < PIXEL_LATENCY; k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign late_flags = dly_q[PIXEL_LATENCY-1];
    end
  endgenerate

  logic                   late_act;
  logic                   late_hs;
  logic                   late_vs;
  logic [COLOR_WIDTH-1:0] red_q;
  logic [COLOR_WIDTH-1:0] green_q;
  logic [COLOR_WIDTH-1:0] blue_q;
  logic                   hsync_q;
  logic                   vsync_q;
  logic                   blank_q;
  logic                   sync_q;

  assign late_act = late_flags[2];
  assign late_hs  = late_flags[1];
  assign late_vs  = late_flags[0];

  // Registered DAC stage; reset leaves the connector blanked with syncs idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hsync_q <= ~HS_ON;
      vsync_q <= ~VS_ON;
      blank_q <= 1'b0;
      sync_q  <= 1'b1;
    end else begin
      red_q   <= late_act ? vga.pixel_red   : '0;
      green_q <= late_act ? vga.pixel_green : '0;
      blue_q  <= late_act ? vga.pixel_blue  : '0;
      hsync_q <= late_hs ? HS_ON : ~HS_ON;
      vsync_q <= late_vs ? VS_ON : ~VS_ON;
      blank_q <= late_act;
      sync_q  <= ~(late_hs | late_vs);
    end
  end

  assign vga.vga_red             = red_q;
  assign vga.vga_green           = green_q;
  assign vga.vga_blue            = blue_q;
  assign vga.vga_horizontal_sync = hsync_q;
  assign vga.vga_vertical_sync   = vsync_q;
  assign vga.vga_blank           = blank_q;
  assign vga.vga_sync            = sync_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench for vga_timing_generator with a reduced raster:
// line = 8 active + 2 FP + 3 sync + 3 BP = 16 clocks, frame = 4 + 1 + 2 + 1 = 8 lines (128 clocks).
// PIXEL_LATENCY = 2, hsync active-low, vsync active-high.
module tb_vga_timing_generator;

  localparam int L  = 2;
  localparam int HT = 16;
  localparam int VT = 8;
  localparam int NMAX = 1024;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  always #5 clk = ~clk;

  vga_timing_generator_if #(.COLOR_WIDTH(8)) vif ();

  vga_timing_generator #(
    .H_ACTIVE(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(3),
    .V_ACTIVE(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
    .HSYNC_POLARITY(0), .VSYNC_POLARITY(1),
    .COLOR_WIDTH(8), .PIXEL_LATENCY(L)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .enable(en),
    .vga   (vif.master)
  );

  typedef struct {
    int          n;
    bit          steady;
    logic [55:0] exp_vec;
  } exp_t;

  exp_t exp_q[$];

  int tests_run = 0;
  int tests_failed = 0;

  // Per-cycle history of the bench's own raster model.
  bit r_h   [NMAX];
  bit e_h   [NMAX];
  int p_h   [NMAX];
  int x_h   [NMAX];
  int y_h   [NMAX];
  bit act_h [NMAX];
  bit hs_h  [NMAX];
  bit vs_h  [NMAX];
  int ncyc = 0;
  bit driver_done = 0;

  // One clock of stimulus: drive inputs just after the edge and queue the
  // outputs expected for this cycle.
  task automatic step(input bit r, input bit e, input bit steady);
    int  n, p, x, y, k, src;
    bit  req, ok;
    bit  e_blank, e_hs, e_vs, e_sync;
    logic [7:0] e_r, e_g, e_b, d_r, d_g, d_b;
    exp_t item;
    @(posedge clk);
    #1;
    n = ncyc;
    rst_n = r;
    en    = e;
    r_h[n] = r;
    e_h[n] = e;
    if (!r) p = 0;
    else if (n > 0 && r_h[n-1] && e_h[n-1]) p = p_h[n-1] + 1;
    else p = 0;
    p_h[n] = p;
    x = p % HT;
    y = (p / HT) % VT;
    x_h[n] = x;
    y_h[n] = y;
    req = e && (x < 8) && (y < 4);
    act_h[n] = req;
    hs_h[n]  = e && (x >= 10) && (x < 13);
    vs_h[n]  = e && (y >= 5) && (y < 7);

    // Colour source answers the request issued L cycles ago.
    k = n - L;
    d_r = (k >= 0) ? 8'(x_h[k]) : 8'd0;
    d_g = (k >= 0) ? 8'(y_h[k]) : 8'd0;
    d_b = (k >= 0) ? 8'(x_h[k] ^ (y_h[k] << 4)) : 8'd0;
    vif.pixel_red   = d_r;
    vif.pixel_green = d_g;
    vif.pixel_blue  = d_b;

    // Registered outputs reflect cycle n-L-1 only if reset stayed high throughout.
    ok = 1;
    for (int j = n - L - 1; j <= n; j++)
      if (j < 0 || !r_h[j]) ok = 0;
    if (ok) begin
      src     = n - L - 1;
      e_blank = act_h[src];
      e_hs    = hs_h[src] ? 1'b0 : 1'b1;
      e_vs    = vs_h[src] ? 1'b1 : 1'b0;
      e_sync  = !(hs_h[src] || vs_h[src]);
      e_r     = act_h[src] ? 8'(x_h[src]) : 8'd0;
      e_g     = act_h[src] ? 8'(y_h[src]) : 8'd0;
      e_b     = act_h[src] ? 8'(x_h[src] ^ (y_h[src] << 4)) : 8'd0;
    end else begin
      e_blank = 1'b0;
      e_hs    = 1'b1;
      e_vs    = 1'b0;
      e_sync  = 1'b1;
      e_r     = 8'd0;
      e_g     = 8'd0;
      e_b     = 8'd0;
    end

    item.n      = n;
    item.steady = steady;
    item.exp_vec = {req,
                    req ? 12'(x) : 12'd0,
                    req ? 12'(y) : 12'd0,
                    e && (p % (HT*VT) == 0),
                    e && (x == 0) && (y == 4),
                    e_blank, e_hs, e_vs, e_sync,
                    e_r, e_g, e_b,
                    1'b0};            // vga_clock follows clk: low at the sampling edge
    exp_q.push_back(item);
    ncyc++;
  endtask

  // Driver
  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    vif.pixel_red   = 8'd0;
    vif.pixel_green = 8'd0;
    vif.pixel_blue  = 8'd0;
    // Reset with enable high
    repeat (3) step(1'b0, 1'b1, 1'b0);
    // Free run a bit over two frames
    repeat (300) step(1'b1, 1'b1, 1'b1);
    // Drop enable mid-frame for 10 cycles, then resume
    repeat (10) step(1'b1, 1'b0, 1'b0);
    repeat (60) step(1'b1, 1'b1, 1'b0);
    // Reset pulse mid-line, then resume
    repeat (2) step(1'b0, 1'b1, 1'b0);
    repeat (150) step(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    driver_done = 1;
  end

  // Monitor: compares every presented cycle against the queued expectation,
  // plus hand-computed period/width checks during the undisturbed run.
  logic [55:0] act_vec;
  int last_fs = -1;
  bit prev_hs = 1'b1;
  bit run_valid = 0;
  int run_len = 0;

  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        act_vec = {vif.pixel_request, vif.pixel_x_pos, vif.pixel_y_pos,
                   vif.frame_start, vif.vblank_start,
                   vif.vga_blank, vif.vga_horizontal_sync, vif.vga_vertical_sync, vif.vga_sync,
                   vif.vga_red, vif.vga_green, vif.vga_blue, vif.vga_clock};
        tests_run++;
        if (act_vec !== it.exp_vec) begin
          tests_failed++;
          $display("FAIL cycle%0d outputs got=%h want=%h (req,x,y,fs,vb,blank,hs,vs,sync,r,g,b,clk)",
                   it.n, act_vec, it.exp_vec);
        end

        if (it.steady) begin
          if (vif.frame_start === 1'b1) begin
            if (last_fs >= 0) begin
              tests_run++;
              if (it.n - last_fs != 128) begin
                tests_failed++;
                $display("FAIL frame_period got=%0d want=128", it.n - last_fs);
              end
            end
            last_fs = it.n;
          end
          if (vif.vblank_start === 1'b1 && last_fs >= 0) begin
            tests_run++;
            if (it.n - last_fs != 64) begin
              tests_failed++;
              $display("FAIL vblank_offset got=%0d want=64", it.n - last_fs);
            end
          end
          if (vif.vga_horizontal_sync === 1'b0) begin
            if (prev_hs) begin
              run_valid = 1;
              run_len = 1;
            end else begin
              run_len++;
            end
          end else if (!prev_hs && run_valid) begin
            tests_run++;
            if (run_len != 3) begin
              tests_failed++;
              $display("FAIL hsync_width got=%0d want=3", run_len);
            end
            run_valid = 0;
          end
        end else begin
          last_fs = -1;
          run_valid = 0;
        end
        prev_hs = vif.vga_horizontal_sync;
      end
    end
  end

  // Summary once the driver is done and the scoreboard has drained.
  initial begin
    wait (driver_done == 1);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
